// File: rtl/chacha_pkg.sv
// Shared constants, state type and helpers for the ChaCha stream core.
// State word 0 lives in the most significant 32 bits of a 512-bit block.
package chacha_pkg;

    localparam logic [127:0] SIGMA = 128'h61707865_3320646e_79622d32_6b206574;
    localparam logic [127:0] TAU   = 128'h61707865_3120646e_79622d36_6b206574;

    localparam int N_WORDS = 16;
    localparam int W_KEY   = 4;
    localparam int W_CTR   = 12;

    typedef logic [N_WORDS-1:0][31:0] state_t;

    typedef enum logic [1:0] {
        UNKEYED,
        IDLE,
        RUN,
        OUT
    } fsm_e;

    function automatic bit params_ok(int r, int kw, int cw);
        return (r >= 2) && (r <= 510) && (r % 2 == 0) &&
               (kw == 128 || kw == 256) &&
               (cw == 32 || cw == 64);
    endfunction

    function automatic logic [31:0] rotl(logic [31:0] v, int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [127:0] qr(logic [31:0] a_i, logic [31:0] b_i,
                                        logic [31:0] c_i, logic [31:0] d_i);
        logic [31:0] a, b, c, d;
        a = a_i; b = b_i; c = c_i; d = d_i;
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        return {a, b, c, d};
    endfunction

    function automatic state_t mk_state(logic [127:0] cst, logic [255:0] k,
                                        logic [127:0] tail);
        state_t s;
        for (int i = 0; i < N_WORDS; i++) begin
            if (i < W_KEY)
                s[N_WORDS-1-i] = cst[127-32*i -: 32];
            else if (i < W_CTR)
                s[N_WORDS-1-i] = k[255-32*(i-W_KEY) -: 32];
            else
                s[N_WORDS-1-i] = tail[127-32*(i-W_CTR) -: 32];
        end
        return s;
    endfunction

    function automatic state_t add_state(state_t a, state_t b);
        state_t r;
        for (int i = 0; i < N_WORDS; i++)
            r[i] = a[i] + b[i];
        return r;
    endfunction

endpackage

// File: rtl/chacha_stream_core_if.sv
// Block streaming handshake between the data mover and the ChaCha core.
interface chacha_stream_core_if #(
    parameter int CTR_WIDTH = 64
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [511:0]         in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [511:0]         out_data;
    logic [CTR_WIDTH-1:0] out_ctr;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ctr
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ctr
    );
endinterface

// File: rtl/chacha_double_round.sv
// Combinational ChaCha double round: four column then four diagonal QRs.
module chacha_double_round
    import chacha_pkg::*;
(
    input  state_t st_i,
    output state_t st_o
);

    always_comb begin
        logic [31:0] x [N_WORDS];
        for (int i = 0; i < N_WORDS; i++)
            x[i] = st_i[N_WORDS-1-i];

        {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
        {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
        {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
        {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);

        {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
        {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
        {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
        {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);

        st_o = '0;
        for (int i = 0; i < N_WORDS; i++)
            st_o[N_WORDS-1-i] = x[i];
    end

endmodule

// File: rtl/chacha_stream_core.sv
// Streaming ChaCha engine: XORs 512-bit blocks with keystream, one block
// in flight, one double round per cycle, auto-incrementing block counter.
module chacha_stream_core
    import chacha_pkg::*;
#(
    parameter  int ROUNDS    = 20,
    parameter  int KEY_WIDTH = 256,
    parameter  int CTR_WIDTH = 64,
    localparam int NONCE_W   = 128 - CTR_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    input  logic [255:0]         key,
    input  logic [NONCE_W-1:0]   nonce,
    input  logic [CTR_WIDTH-1:0] ctr_init,
    chacha_stream_core_if.slave  bus,
    output logic                 ctr_wrapped,
    output logic                 busy
);

    if (!params_ok(ROUNDS, KEY_WIDTH, CTR_WIDTH)) begin : g_bad_params
        $error("chacha_stream_core: illegal ROUNDS/KEY_WIDTH/CTR_WIDTH");
    end

    localparam logic [7:0] LAST_RND = 8'(ROUNDS / 2 - 1);
    localparam logic [127:0] CONSTS = (KEY_WIDTH == 256) ? SIGMA : TAU;

    fsm_e                 st_q, st_d;
    logic [255:0]         key_q, key_d;
    logic [NONCE_W-1:0]   nonce_q, nonce_d;
    logic [CTR_WIDTH-1:0] ctr_q, ctr_d;
    logic [CTR_WIDTH-1:0] cand_q, cand_d;
    logic                 wrap_q, wrap_d;
    state_t               work_q, work_d;
    state_t               init_st_q, init_st_d;
    logic [511:0]         data_q, data_d;
    logic [7:0]           round_q, round_d;
    logic                 out_valid_q, out_valid_d;
    logic [511:0]         out_data_q, out_data_d;
    logic [CTR_WIDTH-1:0] out_ctr_q, out_ctr_d;
    logic                 in_ready_q, in_ready_d;
    logic                 busy_q, busy_d;

    state_t dr_out;
    state_t blk_init;

    chacha_double_round u_dr (
        .st_i (work_q),
        .st_o (dr_out)
    );

    assign blk_init = mk_state(CONSTS, key_q, {ctr_q, nonce_q});

    always_comb begin
        st_d        = st_q;
        key_d       = key_q;
        nonce_d     = nonce_q;
        ctr_d       = ctr_q;
        cand_d      = cand_q;
        wrap_d      = wrap_q;
        work_d      = work_q;
        init_st_d   = init_st_q;
        data_d      = data_q;
        round_d     = round_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ctr_d   = out_ctr_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;

        // init overrides everything, including a same-cycle handshake
        if (init) begin
            key_d       = (KEY_WIDTH == 256) ? key : {key[127:0], key[127:0]};
            nonce_d     = nonce;
            ctr_d       = ctr_init;
            wrap_d      = 1'b0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
            st_d        = IDLE;
        end else begin
            case (st_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        data_d     = bus.in_data;
                        work_d     = blk_init;
                        init_st_d  = blk_init;
                        cand_d     = ctr_q;
                        ctr_d      = ctr_q + CTR_WIDTH'(1);
                        wrap_d     = wrap_q | (&ctr_q);
                        round_d    = 8'd0;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b1;
                        st_d       = RUN;
                    end
                end
                RUN: begin
                    if (round_q == LAST_RND) begin
                        out_data_d  = data_q ^ add_state(dr_out, init_st_q);
                        out_ctr_d   = cand_q;
                        out_valid_d = 1'b1;
                        st_d        = OUT;
                    end else begin
                        work_d  = dr_out;
                        round_d = round_q + 8'd1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                        busy_d      = 1'b0;
                        st_d        = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q        <= UNKEYED;
            key_q       <= '0;
            nonce_q     <= '0;
            ctr_q       <= '0;
            cand_q      <= '0;
            wrap_q      <= 1'b0;
            work_q      <= '0;
            init_st_q   <= '0;
            data_q      <= '0;
            round_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ctr_q   <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            st_q        <= st_d;
            key_q       <= key_d;
            nonce_q     <= nonce_d;
            ctr_q       <= ctr_d;
            cand_q      <= cand_d;
            wrap_q      <= wrap_d;
            work_q      <= work_d;
            init_st_q   <= init_st_d;
            data_q      <= data_d;
            round_q     <= round_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ctr_q   <= out_ctr_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ctr   = out_ctr_q;
    assign ctr_wrapped   = wrap_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_chacha_stream_core.sv
// Randomised self-checking bench for chacha_stream_core against a
// word-array ChaCha reference model.
module tb_chacha_stream_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         init;
    logic [255:0] key;
    logic [63:0]  nonce;
    logic [63:0]  ctr_init;
    logic         ctr_wrapped;
    logic         busy;

    logic         p_init;
    logic [255:0] p_key;
    logic [95:0]  p_nonce;
    logic [31:0]  p_ctr_init;
    logic         p_wrapped;
    logic         p_busy;

    int checks = 0;
    int errors = 0;

    chacha_stream_core_if #(.CTR_WIDTH(64)) m_if ();
    chacha_stream_core_if #(.CTR_WIDTH(32)) p_if ();

    chacha_stream_core #(
        .ROUNDS(20), .KEY_WIDTH(256), .CTR_WIDTH(64)
    ) dut (
        .clk(clk), .reset(reset), .init(init), .key(key),
        .nonce(nonce), .ctr_init(ctr_init), .bus(m_if),
        .ctr_wrapped(ctr_wrapped), .busy(busy)
    );

    chacha_stream_core #(
        .ROUNDS(8), .KEY_WIDTH(128), .CTR_WIDTH(32)
    ) dut_p (
        .clk(clk), .reset(reset), .init(p_init), .key(p_key),
        .nonce(p_nonce), .ctr_init(p_ctr_init), .bus(p_if),
        .ctr_wrapped(p_wrapped), .busy(p_busy)
    );

    function automatic logic [31:0] rl(logic [31:0] v, int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // ChaCha block function over a plain word array, returns keystream
    function automatic logic [511:0] ks(int rounds, int kw, int cw,
                                        logic [255:0] k, logic [95:0] n,
                                        logic [63:0] c);
        logic [31:0]  x [16];
        logic [31:0]  s [16];
        logic [127:0] cst;
        logic [127:0] tail;
        logic [511:0] r;
        int qi [8][4];
        int a, b, cc, d;
        qi = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
               '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
        cst = (kw == 256) ? 128'h61707865_3320646e_79622d32_6b206574
                          : 128'h61707865_3120646e_79622d36_6b206574;
        tail = (cw == 64) ? {c, n[63:0]} : {c[31:0], n};
        for (int i = 0; i < 4; i++) s[i] = cst[127-32*i -: 32];
        for (int i = 0; i < 8; i++)
            s[4+i] = (kw == 256) ? k[255-32*i -: 32] : k[127-32*(i%4) -: 32];
        for (int i = 0; i < 4; i++) s[12+i] = tail[127-32*i -: 32];
        x = s;
        for (int rr = 0; rr < rounds / 2; rr++) begin
            for (int j = 0; j < 8; j++) begin
                a = qi[j][0]; b = qi[j][1]; cc = qi[j][2]; d = qi[j][3];
                x[a] = x[a] + x[b];  x[d] = rl(x[d] ^ x[a], 16);
                x[cc] = x[cc] + x[d]; x[b] = rl(x[b] ^ x[cc], 12);
                x[a] = x[a] + x[b];  x[d] = rl(x[d] ^ x[a], 8);
                x[cc] = x[cc] + x[d]; x[b] = rl(x[b] ^ x[cc], 7);
            end
        end
        for (int i = 0; i < 16; i++) r[511-32*i -: 32] = x[i] + s[i];
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(input logic [255:0] k, input logic [63:0] n,
                           input logic [63:0] c);
        key = k; nonce = n; ctr_init = c; init = 1'b1;
        step();
        init = 1'b0;
    endtask

    // Send one block, return latency in cycles and the result observed
    task automatic run_block(input logic [511:0] d, input bit rdy,
                             output int lat, output logic [511:0] od,
                             output logic [63:0] oc);
        int n;
        n = 0;
        while (!m_if.in_ready && n < 50) begin step(); n++; end
        checks++;
        if (m_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_wait got=%b want=1", m_if.in_ready);
        end
        m_if.out_ready = rdy;
        m_if.in_data = d;
        m_if.in_valid = 1'b1;
        lat = 0;
        do begin
            step();
            lat++;
            m_if.in_valid = 1'b0;
            m_if.in_data = rand512();
        end while (!m_if.out_valid && lat < 100);
        checks++;
        if (m_if.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL out_valid_timeout got=%b want=1", m_if.out_valid);
        end
        od = m_if.out_data;
        oc = m_if.out_ctr;
        if (rdy) step();
    endtask

    task automatic test_reset();
        bit bad;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        checks++;
        if ({m_if.in_ready, m_if.out_valid, ctr_wrapped, busy} !== 4'b0 ||
            m_if.out_data !== '0 || m_if.out_ctr !== '0) begin
            errors++;
            $display("FAIL reset_state got=%b%b%b%b want=0000",
                     m_if.in_ready, m_if.out_valid, ctr_wrapped, busy);
        end
        do_init(rand256(), {$urandom, $urandom}, {$urandom, $urandom});
        m_if.in_data = rand512();
        m_if.in_valid = 1'b1;
        step();
        m_if.in_valid = 1'b0;
        step(); step(); step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_run got=%b want=1", busy);
        end
        reset = 1'b1;
        step(); step(); step();
        reset = 1'b0;
        checks++;
        if ({m_if.in_ready, m_if.out_valid, ctr_wrapped, busy} !== 4'b0 ||
            m_if.out_data !== '0 || m_if.out_ctr !== '0) begin
            errors++;
            $display("FAIL reset_mid_run got=%b%b%b%b ctr=%h want=0000 ctr=0",
                     m_if.in_ready, m_if.out_valid, ctr_wrapped, busy,
                     m_if.out_ctr);
        end
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (m_if.out_valid !== 1'b0 || m_if.in_ready !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL unkeyed_quiet got=activity want=none");
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [511:0] od, exp_ks;
        logic [63:0] oc;
        do_init('0, '0, '0);
        run_block('0, 1'b1, lat, od, oc);
        exp_ks = ks(20, 256, 64, '0, '0, '0);
        checks++;
        if (lat !== 11) begin
            errors++;
            $display("FAIL basic_latency got=%0d want=11", lat);
        end
        checks++;
        if (oc !== 64'd0) begin
            errors++;
            $display("FAIL basic_ctr got=%h want=0", oc);
        end
        checks++;
        if (od !== exp_ks) begin
            errors++;
            $display("FAIL basic_data got=%h want=%h", od, exp_ks);
        end
        checks++;
        if (od[511:384] !== 128'hade0b876_903df1a0_e56a5d40_28bd8653) begin
            errors++;
            $display("FAIL basic_known_vector got=%h want=ade0b876903df1a0e56a5d4028bd8653",
                     od[511:384]);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [511:0] od, d, exp;
        logic [63:0] oc, c, n;
        logic [255:0] k;
        for (int t = 0; t < 4; t++) begin
            k = rand256();
            n = {$urandom, $urandom};
            c = {$urandom, $urandom};
            do_init(k, n, c);
            for (int b = 0; b < 2; b++) begin
                d = rand512();
                run_block(d, 1'b1, lat, od, oc);
                exp = d ^ ks(20, 256, 64, k, {32'd0, n}, c + 64'(b));
                checks++;
                if (od !== exp || oc !== c + 64'(b)) begin
                    errors++;
                    $display("FAIL random_block got=%h ctr=%h want=%h ctr=%h",
                             od, oc, exp, c + 64'(b));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit bad;
        logic [511:0] od, d1, d2, exp;
        logic [63:0] oc, c, n;
        logic [255:0] k;
        k = rand256();
        n = {$urandom, $urandom};
        c = {$urandom, $urandom};
        do_init(k, n, c);
        d1 = rand512();
        run_block(d1, 1'b0, lat, od, oc);
        exp = d1 ^ ks(20, 256, 64, k, {32'd0, n}, c);
        checks++;
        if (od !== exp || oc !== c) begin
            errors++;
            $display("FAIL bp_first got=%h ctr=%h want=%h ctr=%h", od, oc, exp, c);
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (m_if.out_valid !== 1'b1 || m_if.out_data !== exp ||
                m_if.out_ctr !== c || m_if.in_ready !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bp_hold got=v%b r%b ctr=%h want=v1 r0 ctr=%h",
                     m_if.out_valid, m_if.in_ready, m_if.out_ctr, c);
        end
        m_if.out_ready = 1'b1;
        step();
        checks++;
        if (m_if.out_valid !== 1'b0 || m_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got=v%b r%b want=v0 r1",
                     m_if.out_valid, m_if.in_ready);
        end
        d2 = rand512();
        run_block(d2, 1'b1, lat, od, oc);
        exp = d2 ^ ks(20, 256, 64, k, {32'd0, n}, c + 64'd1);
        checks++;
        if (od !== exp || oc !== c + 64'd1 || lat !== 11) begin
            errors++;
            $display("FAIL b2b_second got=%h ctr=%h lat=%0d want=%h ctr=%h lat=11",
                     od, oc, lat, exp, c + 64'd1);
        end
    endtask

    task automatic test_wrap();
        int lat;
        logic [511:0] od, d, exp;
        logic [63:0] oc, n;
        logic [255:0] k;
        k = rand256();
        n = {$urandom, $urandom};
        do_init(k, n, '1);
        for (int b = 0; b < 2; b++) begin
            d = rand512();
            run_block(d, 1'b1, lat, od, oc);
            exp = d ^ ks(20, 256, 64, k, {32'd0, n}, 64'('1) + 64'(b));
            checks++;
            if (od !== exp || oc !== 64'('1) + 64'(b) || ctr_wrapped !== 1'b1) begin
                errors++;
                $display("FAIL wrap_block%0d got=ctr %h wr %b want=ctr %h wr 1",
                         b, oc, ctr_wrapped, 64'('1) + 64'(b));
            end
        end
        do_init(k, n, 64'd5);
        checks++;
        if (ctr_wrapped !== 1'b0) begin
            errors++;
            $display("FAIL wrap_clear got=%b want=0", ctr_wrapped);
        end
    endtask

    task automatic test_abort();
        int lat;
        bit bad;
        logic [511:0] od, d, exp;
        logic [63:0] oc, cb, nb;
        logic [255:0] kb;
        do_init(rand256(), {$urandom, $urandom}, {$urandom, $urandom});
        m_if.in_data = rand512();
        m_if.in_valid = 1'b1;
        step();
        m_if.in_valid = 1'b0;
        step(); step(); step(); step();
        kb = rand256();
        nb = {$urandom, $urandom};
        cb = {$urandom, $urandom};
        do_init(kb, nb, cb);
        bad = (busy !== 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (m_if.out_valid !== 1'b0) bad = 1'b1;
            step();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL abort_no_output got=activity want=none");
        end
        d = rand512();
        run_block(d, 1'b1, lat, od, oc);
        exp = d ^ ks(20, 256, 64, kb, {32'd0, nb}, cb);
        checks++;
        if (od !== exp || oc !== cb) begin
            errors++;
            $display("FAIL abort_next got=%h ctr=%h want=%h ctr=%h", od, oc, exp, cb);
        end
        key = kb; nonce = nb; ctr_init = cb;
        m_if.in_data = rand512();
        init = 1'b1;
        m_if.in_valid = 1'b1;
        step();
        init = 1'b0;
        m_if.in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || m_if.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL init_wins got=busy %b rdy %b want=busy 0 rdy 1",
                     busy, m_if.in_ready);
        end
        d = rand512();
        run_block(d, 1'b1, lat, od, oc);
        checks++;
        if (oc !== cb) begin
            errors++;
            $display("FAIL init_wins_ctr got=%h want=%h", oc, cb);
        end
    endtask

    task automatic test_params();
        int lat;
        logic [511:0] od, d, exp;
        logic [31:0] c, oc;
        logic [95:0] n;
        logic [255:0] k;
        k = rand256();
        n = {$urandom, $urandom, $urandom};
        c = $urandom;
        p_key = k; p_nonce = n; p_ctr_init = c; p_init = 1'b1;
        step();
        p_init = 1'b0;
        p_if.out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            d = rand512();
            p_if.in_data = d;
            p_if.in_valid = 1'b1;
            lat = 0;
            do begin
                step();
                lat++;
                p_if.in_valid = 1'b0;
                p_if.in_data = rand512();
            end while (!p_if.out_valid && lat < 100);
            od = p_if.out_data;
            oc = p_if.out_ctr;
            step();
            exp = d ^ ks(8, 128, 32, k, n, {32'd0, c + 32'(b)});
            checks++;
            if (od !== exp || oc !== c + 32'(b) || lat !== 5) begin
                errors++;
                $display("FAIL params_block%0d got=%h ctr=%h lat=%0d want=%h ctr=%h lat=5",
                         b, od, oc, lat, exp, c + 32'(b));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        init = 1'b0;
        key = '0; nonce = '0; ctr_init = '0;
        p_init = 1'b0;
        p_key = '0; p_nonce = '0; p_ctr_init = '0;
        m_if.in_valid = 1'b0;
        m_if.in_data = '0;
        m_if.out_ready = 1'b1;
        p_if.in_valid = 1'b0;
        p_if.in_data = '0;
        p_if.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_wrap();
        test_abort();
        test_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
